// File: rtl/tqvp_uart_tx_arb_if.sv
// Bundle between the UART TX arbiter, its byte requesters and the shared transmitter.
// The master side is the requesters plus transmitter; the slave side is the arbiter.
interface tqvp_uart_tx_arb_if #(
  parameter int NUM_REQ      = 2,
  parameter int PAYLOAD_BITS = 8
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]              req_lock;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            uart_tx_en;
  logic [PAYLOAD_BITS-1:0]         uart_tx_data;
  logic                            uart_tx_busy;
  logic [1:0]                      grant_id;
  logic                            arb_active;

  modport master (
    output req_valid, req_data, req_lock, uart_tx_busy,
    input  req_ready, uart_tx_en, uart_tx_data, grant_id, arb_active
  );

  modport slave (
    input  req_valid, req_data, req_lock, uart_tx_busy,
    output req_ready, uart_tx_en, uart_tx_data, grant_id, arb_active
  );
endinterface

// File: rtl/tqvp_uart_tx_arb.sv
// Round-robin scheduler sharing one tqvp_uart_tx transmitter among NUM_REQ byte requesters.
// Optional multi-byte frame lock is built only when UART_TX_ARB_LOCK_EN is defined.
module tqvp_uart_tx_arb #(
  parameter int NUM_REQ      = 2,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  tqvp_uart_tx_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              grant_q, grant_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;

  logic [3:0]              valid_w;
  logic [PAYLOAD_BITS-1:0] byte_w [4];
  logic [3:0]              eligible;
  logic [3:0]              ready_w;
  logic                    found;
  logic [1:0]              win;
  logic                    handshake;

  // Requester vectors are padded to four slots so a 2-bit index never falls off the end.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      if (gi < NUM_REQ) begin : g_used
        assign valid_w[gi] = bus.req_valid[gi];
        assign byte_w[gi]  = bus.req_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
      end else begin : g_pad
        assign valid_w[gi] = 1'b0;
        assign byte_w[gi]  = '0;
      end
    end
  endgenerate

`ifdef UART_TX_ARB_LOCK_EN
  logic       lock_q, lock_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] lock_w;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lock
      if (gi < NUM_REQ) begin : g_used
        assign lock_w[gi] = bus.req_lock[gi];
      end else begin : g_pad
        assign lock_w[gi] = 1'b0;
      end
    end
  endgenerate

  // The registered owner stays exclusive for the whole IDLE cycle in which it drops req_lock.
  assign eligible = lock_q ? (valid_w & (4'b0001 << owner_q)) : valid_w;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (handshake) begin
      lock_d  = lock_w[win];
      owner_d = win;
    end else if (state_q == IDLE && lock_q && !lock_w[owner_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= 2'd0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  assign eligible = valid_w;
`endif

  // Scan from ptr upward; iterating backwards lets the nearest candidate overwrite the rest.
  always_comb begin
    logic [2:0] idx;
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      if (k < NUM_REQ) begin
        idx = {1'b0, ptr_q} + 3'(k);
        if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
        if (eligible[idx[1:0]]) begin
          found = 1'b1;
          win   = idx[1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ready_w = 4'b0000;
    case (state_q)
      IDLE: begin
        if (!bus.uart_tx_busy && found) ready_w = 4'b0001 << win;
        if (handshake) begin
          data_d  = byte_w[win];
          grant_d = win;
          ptr_d   = (int'(win) == NUM_REQ - 1) ? 2'd0 : win + 2'd1;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.uart_tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.uart_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign handshake = |(ready_w & valid_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready    = ready_w[NUM_REQ-1:0];
  assign bus.uart_tx_en   = (state_q == ISSUE);
  assign bus.uart_tx_data = data_q;
  assign bus.grant_id     = grant_q;
  assign bus.arb_active   = (state_q != IDLE);
endmodule

// File: tb/tb_tqvp_uart_tx_arb.sv
// Scoreboard bench for tqvp_uart_tx_arb with three requesters and a simple busy-only transmitter model.
module tb_tqvp_uart_tx_arb;
  localparam int NR    = 3;
  localparam int PB    = 8;
  localparam int FRAME = 10;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_busy = 1'b0;
  int   tx_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  tqvp_uart_tx_arb_if #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) bus ();

  tqvp_uart_tx_arb #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Transmitter stand-in: busy from the cycle after the start pulse for FRAME cycles.
  always @(posedge clk) begin
    if (bus.uart_tx_en) tx_cnt <= FRAME;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.uart_tx_busy = (tx_cnt != 0) | force_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every start pulse is matched against the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && bus.uart_tx_en) begin
      $display("tx: grant=%0d data=%02h", bus.grant_id, bus.uart_tx_data);
      check("tx_en_not_back_to_back", {31'd0, en_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_tx", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_grant_id", {30'd0, bus.grant_id}, {30'd0, mon_e.id});
        check("tx_data", {24'd0, bus.uart_tx_data}, {24'd0, mon_e.data});
      end
    end
    en_prev = bus.uart_tx_en;
  end

  task automatic wait_hs(output int id, input int budget);
    bit done;
    done = 0;
    id   = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != '0) begin
        for (int i = 0; i < NR; i++)
          if (bus.req_valid[i] && bus.req_ready[i]) id = i;
        done = 1;
      end
    end
    if (!done) check("handshake_timeout", 32'd1, 32'd0);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!bus.arb_active && !bus.uart_tx_busy) done = 1;
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int id;
  int k1;
  int order_c[4] = '{0, 1, 2, 0};
  logic [7:0] b1[3] = '{8'hB1, 8'hB2, 8'hB3};
  int order_l[4];

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_lock  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {29'd0, bus.req_ready}, 32'd0);
    check("rst_tx_en", {31'd0, bus.uart_tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, bus.uart_tx_data}, 32'd0);
    check("rst_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("rst_arb_active", {31'd0, bus.arb_active}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single byte from requester 0: pulse in T+1 only, active drops the cycle after busy falls.
    push(0, 8'hA5);
    bus.req_data[0 +: 8] = 8'hA5;
    bus.req_valid = 3'b001;
    wait_hs(id, 20);
    bus.req_valid = '0;
    check("single_grant", id, 0);
    @(negedge clk);
    check("single_en_t1", {31'd0, bus.uart_tx_en}, 32'd1);
    @(negedge clk);
    check("single_en_t2", {31'd0, bus.uart_tx_en}, 32'd0);
    for (int c = 0; c < 40 && bus.uart_tx_busy; c++) @(negedge clk);
    check("single_active_busy_fell", {31'd0, bus.arb_active}, 32'd1);
    @(negedge clk);
    check("single_active_dropped", {31'd0, bus.arb_active}, 32'd0);
    wait_idle();

    // Contention with every requester valid: 0,1,2 then wrap to 0.
    do_reset();
    for (int i = 0; i < 4; i++) push(order_c[i], 8'h10 * (order_c[i] + 1));
    bus.req_data  = {8'h30, 8'h20, 8'h10};
    bus.req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_hs(id, 60);
      check("contention_grant", id, order_c[i]);
    end
    bus.req_valid = '0;
    wait_idle();

    // Busy gating: no ready while busy is high, handshake on the first low cycle.
    force_busy = 1'b1;
    bus.req_data  = {8'h00, 8'h5C, 8'h00};
    bus.req_valid = 3'b010;
    repeat (4) begin
      @(negedge clk);
      check("busy_gate_ready", {29'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    push(1, 8'h5C);
    @(negedge clk);
    check("busy_release_ready", {29'd0, bus.req_ready}, 32'b010);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    check("busy_release_grant", {30'd0, bus.grant_id}, 32'd1);
    wait_idle();

    // Reset during WAIT_DONE after a grant to requester 1 (ptr would otherwise point at 2).
    push(1, 8'h42);
    bus.req_data  = {8'h00, 8'h42, 8'h00};
    bus.req_valid = 3'b010;
    wait_hs(id, 20);
    bus.req_valid = '0;
    check("prereset_grant", id, 1);
    for (int c = 0; c < 10 && !bus.uart_tx_busy; c++) @(negedge clk);
    @(posedge clk);
    #1;
    check("prereset_active", {31'd0, bus.arb_active}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready", {29'd0, bus.req_ready}, 32'd0);
    check("midrst_tx_en", {31'd0, bus.uart_tx_en}, 32'd0);
    check("midrst_tx_data", {24'd0, bus.uart_tx_data}, 32'd0);
    check("midrst_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("midrst_arb_active", {31'd0, bus.arb_active}, 32'd0);
    bus.req_data  = {8'h77, 8'h00, 8'h11};
    bus.req_valid = 3'b101;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 8'h11);
    wait_hs(id, 40);
    bus.req_valid = '0;
    check("postreset_grant", id, 0);
    wait_idle();

    // Lock: requester 1 sends three bytes, lock high on the first two; requester 0 waits.
`ifdef UART_TX_ARB_LOCK_EN
    order_l = '{1, 1, 1, 0};
    push(1, 8'hB1); push(1, 8'hB2); push(1, 8'hB3); push(0, 8'h0F);
`else
    order_l = '{1, 0, 1, 1};
    push(1, 8'hB1); push(0, 8'h0F); push(1, 8'hB2); push(1, 8'hB3);
`endif
    k1 = 0;
    bus.req_data  = {8'h00, b1[0], 8'h0F};
    bus.req_lock  = 3'b010;
    bus.req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      wait_hs(id, 60);
      check("lock_order", id, order_l[i]);
      if (id == 1) begin
        k1++;
        if (k1 < 3) begin
          bus.req_data[8 +: 8] = b1[k1];
          bus.req_lock[1] = (k1 < 2);
        end else begin
          bus.req_valid[1] = 1'b0;
          bus.req_lock[1]  = 1'b0;
        end
      end else if (id == 0) begin
        bus.req_valid[0] = 1'b0;
      end
    end
    bus.req_valid = '0;
    bus.req_lock  = '0;
    wait_idle();

    // Valid withdrawal: requester 0 wins, withdraws before the edge, requester 1 is taken.
    do_reset();
    force_busy = 1'b1;
    bus.req_data  = {8'h00, 8'h99, 8'hEE};
    bus.req_valid = 3'b011;
    @(negedge clk);
    check("withdraw_gated_ready", {29'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    push(1, 8'h99);
    @(negedge clk);
    check("withdraw_ready_r0", {29'd0, bus.req_ready}, 32'b001);
    #1;
    bus.req_valid[0] = 1'b0;
    #1;
    check("withdraw_ready_r1", {29'd0, bus.req_ready}, 32'b010);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    check("withdraw_grant", {30'd0, bus.grant_id}, 32'd1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
